portas_logicas: RTL and testbench
=================================

Name: portas_logicas

Overview:
- Bitwise logic-gate unit: computes AND, OR, NAND, NOR, XOR, XNOR and NOT of two WIDTH-bit operands, plus a 1-bit equality flag.
- All results are registered, giving one clock of latency.
- Used as a small shared logic-evaluation leaf block; no handshake beyond a load enable.

Parameters:
- WIDTH, 3, bit width of operands a, b and of outputs s1..s7 (legal range 1 to 64).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  load enable; when 1, the output registers capture new results on the rising edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- s1  output  WIDTH  a AND b, bitwise.
- s2  output  WIDTH  a OR b, bitwise.
- s3  output  WIDTH  a NAND b, bitwise.
- s4  output  WIDTH  a NOR b, bitwise.
- s5  output  WIDTH  a XOR b, bitwise.
- s6  output  WIDTH  a XNOR b, bitwise.
- s7  output  WIDTH  NOT a, bitwise.
- s8  output  1  equality flag: 1 when a == b across all WIDTH bits, else 0.

Behaviour:
- Reset: rst_n low asserts immediately, independent of clk.
  - s1..s7 clear to all zeros and s8 clears to 0.
  - These are the reset values even though a=b=0 would produce s3/s4/s6/s7 = all ones and s8 = 1.
  - Outputs stay at the reset values while rst_n is low.
- Reset release is synchronous to clk. The first capture happens on the first rising edge with rst_n high and en high.
- Capture: on a rising edge with en=1, every output register loads the combinational function of the current a and b.
  - Latency is exactly 1 cycle from the sampling edge.
- Hold: on a rising edge with en=0, every output holds its previous value. a and b are ignored.
- Result coherence: all eight outputs always reflect the same sampled (a, b) pair. No partial updates.
- Reset mid-operation: asserting rst_n discards any pending capture. Outputs read zeros from the assertion instant.
- Arithmetic and width rules:
  - Pure bitwise operations; bit i of s1..s7 depends only on a[i] and b[i].
  - s8 is the AND-reduction of s6's combinational value.
  - No carries, no sign handling; X inputs propagate per standard operator semantics.
- No internal state other than the output registers.

Decomposition:
- Shared package portas_logicas_pkg holds the default WIDTH constant and a localparam naming each output's operation (OP_AND .. OP_EQ) for use in bench scoreboards.
- One sub-module: portas_logicas_core, purely combinational, WIDTH-parameterised, producing all eight results from a and b.
- The top-level portas_logicas instantiates portas_logicas_core and adds the enable-gated, async-reset output registers.

Test Plan:
- Reset: drive rst_n=0 with a=000, b=000 and toggle clk -> s1..s7 = 000, s8 = 0. Release rst_n, set en=1, one edge -> s1=000, s2=000, s3=111, s4=111, s5=000, s6=111, s7=111, s8=1.
- a=010, b=011, en=1, one edge -> s1=010, s2=011, s3=101, s4=100, s5=001, s6=110, s7=101, s8=0.
- a=110, b=101 -> s1=100, s2=111, s3=011, s4=000, s5=011, s6=100, s7=001, s8=0. Then a=101, b=110 -> s1=100, s2=111, s3=011, s4=000, s5=011, s6=100, s7=010, s8=0.
- a=111, b=000 -> s1=000, s2=111, s3=111, s4=000, s5=111, s6=000, s7=000, s8=0. Then a=111, b=111 -> s1=111, s2=111, s3=000, s4=000, s5=000, s6=111, s7=000, s8=1.
- Hold: capture a=010, b=011, set en=0, change to a=111, b=111 for 5 edges -> outputs remain at the 010/011 results. Set en=1 -> the 111/111 results appear after one edge.
- Async reset mid-run: with non-zero outputs, pull rst_n low between clock edges -> all outputs read zero before the next edge.

Source files
------------

// File: rtl/portas_logicas_pkg.sv
// -----------------------------------------------------------------------------
// portas_logicas_pkg
//
// Purpose:
//   Shared constants for the bitwise logic-gate unit. It holds the default
//   operand width and one index constant per output operation. Scoreboards can
//   use these indices to keep the eight results in an array in a fixed order.
//
// Contents:
//   DEFAULT_WIDTH  default operand/result width (legal range 1..64)
//   MAX_WIDTH      widest legal operand
//   OP_AND..OP_EQ  index of each output operation (s1..s8 order)
//   NUM_OPS        number of results produced by the unit
//   width_is_legal helper used by the design to guard its WIDTH parameter
// -----------------------------------------------------------------------------
package portas_logicas_pkg;

  localparam int DEFAULT_WIDTH = 3;
  localparam int MAX_WIDTH     = 64;

  // Output index constants, in port order s1..s8.
  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_NAND = 2;
  localparam int OP_NOR  = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_XNOR = 5;
  localparam int OP_NOT  = 6;
  localparam int OP_EQ   = 7;

  localparam int NUM_OPS = 8;

  // True when a width lies inside the supported range.
  function automatic bit width_is_legal(input int w);
    return (w >= 1) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/portas_logicas_core.sv
// -----------------------------------------------------------------------------
// portas_logicas_core
//
// Purpose:
//   Purely combinational evaluation of the seven bitwise gates and the
//   equality flag for two WIDTH-bit operands. This module has no state.
//   Registering and enable gating happen in the top level.
//
// Parameters:
//   WIDTH     operand/result width, 1..64
//
// Ports:
//   a         input  [WIDTH-1:0]  operand A
//   b         input  [WIDTH-1:0]  operand B
//   and_res   output [WIDTH-1:0]  a & b
//   or_res    output [WIDTH-1:0]  a | b
//   nand_res  output [WIDTH-1:0]  ~(a & b)
//   nor_res   output [WIDTH-1:0]  ~(a | b)
//   xor_res   output [WIDTH-1:0]  a ^ b
//   xnor_res  output [WIDTH-1:0]  ~(a ^ b)
//   not_res   output [WIDTH-1:0]  ~a
//   eq_res    output              1 when a == b on every bit
// -----------------------------------------------------------------------------
module portas_logicas_core
  import portas_logicas_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] and_res,
  output logic [WIDTH-1:0] or_res,
  output logic [WIDTH-1:0] nand_res,
  output logic [WIDTH-1:0] nor_res,
  output logic [WIDTH-1:0] xor_res,
  output logic [WIDTH-1:0] xnor_res,
  output logic [WIDTH-1:0] not_res,
  output logic             eq_res
);

  logic [WIDTH-1:0] xnor_val;

  assign xnor_val = ~(a ^ b);

  assign and_res  = a & b;
  assign or_res   = a | b;
  assign nand_res = ~(a & b);
  assign nor_res  = ~(a | b);
  assign xor_res  = a ^ b;
  assign xnor_res = xnor_val;
  assign not_res  = ~a;

  // Equality is the AND-reduction of the XNOR vector. This keeps X
  // propagation consistent with the bitwise results instead of using ==.
  assign eq_res = &xnor_val;

endmodule

// File: rtl/portas_logicas.sv
// -----------------------------------------------------------------------------
// portas_logicas
//
// Purpose:
//   Registered bitwise logic-gate unit. On each rising clock edge with en high,
//   all eight results of the current (a, b) pair are captured together. The
//   results appear one cycle later. With en low the outputs hold their values.
//   Reset clears every output to zero, even where a zero input would produce
//   ones.
//
// Parameters:
//   WIDTH  operand/result width, 1..64
//
// Ports:
//   clk    input         system clock, rising edge
//   rst_n  input         asynchronous active-low reset
//   en     input         load enable for the output registers
//   a      input  [W]    operand A
//   b      input  [W]    operand B
//   s1     output [W]    a AND b
//   s2     output [W]    a OR b
//   s3     output [W]    a NAND b
//   s4     output [W]    a NOR b
//   s5     output [W]    a XOR b
//   s6     output [W]    a XNOR b
//   s7     output [W]    NOT a
//   s8     output        a == b
// -----------------------------------------------------------------------------
module portas_logicas
  import portas_logicas_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] s3,
  output logic [WIDTH-1:0] s4,
  output logic [WIDTH-1:0] s5,
  output logic [WIDTH-1:0] s6,
  output logic [WIDTH-1:0] s7,
  output logic             s8
);

  if (!width_is_legal(WIDTH)) begin : g_bad_width
    $error("portas_logicas: WIDTH must be between 1 and 64");
  end

  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] or_res;
  logic [WIDTH-1:0] nand_res;
  logic [WIDTH-1:0] nor_res;
  logic [WIDTH-1:0] xor_res;
  logic [WIDTH-1:0] xnor_res;
  logic [WIDTH-1:0] not_res;
  logic             eq_res;

  portas_logicas_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a        (a),
    .b        (b),
    .and_res  (and_res),
    .or_res   (or_res),
    .nand_res (nand_res),
    .nor_res  (nor_res),
    .xor_res  (xor_res),
    .xnor_res (xnor_res),
    .not_res  (not_res),
    .eq_res   (eq_res)
  );

  // All eight registers share one enable and one reset. Because of this they
  // always show results from the same sampled operand pair. Reset values are
  // all zero by design, not the function of a=b=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
      s5 <= '0;
      s6 <= '0;
      s7 <= '0;
      s8 <= 1'b0;
    end else if (en) begin
      s1 <= and_res;
      s2 <= or_res;
      s3 <= nand_res;
      s4 <= nor_res;
      s5 <= xor_res;
      s6 <= xnor_res;
      s7 <= not_res;
      s8 <= eq_res;
    end
  end

endmodule

// File: tb/tb_portas_logicas.sv
// -----------------------------------------------------------------------------
// tb_portas_logicas
//
// Purpose:
//   Self-checking bench for portas_logicas. The reference model counts the
//   ones in each bit pair (a[i] + b[i]) and derives every gate from that count.
//   It compares the operands as integers for equality. The model tracks the
//   registered state: it updates on enabled edges, holds otherwise, and clears
//   on reset.
// -----------------------------------------------------------------------------
module tb_portas_logicas;
  import portas_logicas_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] s1, s2, s3, s4, s5, s6, s7;
  logic         s8;

  int total = 0;
  int bad   = 0;

  logic [63:0] expected [NUM_OPS];
  string op_tag [NUM_OPS] = '{"s1_and", "s2_or", "s3_nand", "s4_nor",
                              "s5_xor", "s6_xnor", "s7_not", "s8_eq"};

  portas_logicas #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .a     (a),
    .b     (b),
    .s1    (s1),
    .s2    (s2),
    .s3    (s3),
    .s4    (s4),
    .s5    (s5),
    .s6    (s6),
    .s7    (s7),
    .s8    (s8)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] required);
    total++;
    if (observed !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, required);
    end
  endtask

  // Reset value of the registered model.
  task automatic clearModel();
    for (int k = 0; k < NUM_OPS; k++) expected[k] = '0;
  endtask

  // Gate results derived from the number of ones in each bit pair.
  task automatic computeModel(input logic [W-1:0] op_a, input logic [W-1:0] op_b);
    clearModel();
    for (int i = 0; i < W; i++) begin
      int ones;
      ones = int'(op_a[i]) + int'(op_b[i]);
      expected[OP_AND][i]  = (ones == 2);
      expected[OP_OR][i]   = (ones >= 1);
      expected[OP_NAND][i] = (ones != 2);
      expected[OP_NOR][i]  = (ones == 0);
      expected[OP_XOR][i]  = (ones == 1);
      expected[OP_XNOR][i] = (ones != 1);
      expected[OP_NOT][i]  = (op_a[i] == 1'b0);
    end
    expected[OP_EQ] = (int'(op_a) == int'(op_b)) ? 64'd1 : 64'd0;
  endtask

  // Compares all eight outputs against the model.
  task automatic checkAll(input string tag);
    logic [63:0] observed [NUM_OPS];
    observed[OP_AND]  = 64'(s1);
    observed[OP_OR]   = 64'(s2);
    observed[OP_NAND] = 64'(s3);
    observed[OP_NOR]  = 64'(s4);
    observed[OP_XOR]  = 64'(s5);
    observed[OP_XNOR] = 64'(s6);
    observed[OP_NOT]  = 64'(s7);
    observed[OP_EQ]   = 64'(s8);
    for (int k = 0; k < NUM_OPS; k++)
      checkOutput($sformatf("%s/%s", tag, op_tag[k]), observed[k], expected[k]);
  endtask

  // Drives one operand pair and enable for a single edge, then checks outputs 1 time unit after the edge.
  task automatic applyStimulus(input logic [W-1:0] na, input logic [W-1:0] nb,
                               input logic nen, input string tag);
    a  = na;
    b  = nb;
    en = nen;
    @(posedge clk);
    if (nen && rst_n) computeModel(na, nb);
    #1;
    checkAll(tag);
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    a     = '0;
    b     = '0;
    clearModel();

    // Reset with en high must still keep the outputs at zero.
    #2 rst_n = 1'b0;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkAll("reset");

    // Release away from the edge; the first capture is the next enabled edge.
    rst_n = 1'b1;
    applyStimulus(3'b000, 3'b000, 1'b1, "zero");
    applyStimulus(3'b010, 3'b011, 1'b1, "p010_011");
    applyStimulus(3'b110, 3'b101, 1'b1, "p110_101");
    applyStimulus(3'b101, 3'b110, 1'b1, "p101_110");
    applyStimulus(3'b111, 3'b000, 1'b1, "p111_000");
    applyStimulus(3'b111, 3'b111, 1'b1, "p111_111");

    // Hold: outputs keep the 010/011 results while en is low.
    applyStimulus(3'b010, 3'b011, 1'b1, "hold_load");
    for (int n = 0; n < 5; n++)
      applyStimulus(3'b111, 3'b111, 1'b0, $sformatf("hold%0d", n));
    applyStimulus(3'b111, 3'b111, 1'b1, "hold_release");

    // Asynchronous reset between edges with nonzero outputs.
    applyStimulus(3'b010, 3'b011, 1'b1, "pre_async");
    #2 rst_n = 1'b0;
    #1;
    clearModel();
    checkAll("async_rst");
    applyStimulus(3'b110, 3'b001, 1'b1, "in_rst");
    rst_n = 1'b1;
    applyStimulus(3'b110, 3'b001, 1'b1, "post_rst");

    // Random operands and enable; equal operands are forced now and then.
    for (int n = 0; n < 200; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         ren;
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      ren = ($urandom_range(0, 3) != 0);
      applyStimulus(ra, rb, ren, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
